accumulator_scheduler: RTL and testbench
========================================

# accumulator_scheduler

Round-robin scheduler that shares one signed accumulator datapath (P <= P ± A, one-cycle registered update, synchronous clear) among NUM_REQ requesters. Each requester submits a job of a given sample count and add/subtract mode. The scheduler grants one job at a time and clears the accumulator. It streams the granted requester's samples into the accumulator, then returns the final P tagged with the requester id. It sits between the requester lanes and the accumulator instance in the DSP design.

## Interface
- NUM_REQ, 4, number of requester lanes (2..8)
- A_WIDTH, 20, signed sample width (accumulator A)
- P_WIDTH, 38, signed result width (accumulator P); must be >= A_WIDTH+LEN_WIDTH
- LEN_WIDTH, 8, job length field width
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  job pending per lane; held until req_ready
- req_sub  in  NUM_REQ  per-lane mode: 1 = P-A, 0 = P+A
- req_len  in  NUM_REQ*LEN_WIDTH  per-lane sample count; lane i at [i*LEN_WIDTH +: LEN_WIDTH]
- req_ready  out  NUM_REQ  one-hot, one-cycle job-accept pulse
- smp_data  in  NUM_REQ*A_WIDTH  per-lane signed sample
- smp_valid  in  NUM_REQ  per-lane sample valid
- smp_ready  out  NUM_REQ  high only on the granted lane in RUN
- acc_a  out  A_WIDTH  to accumulator A
- acc_subtract  out  1  to accumulator subtract_i
- acc_reset  out  1  to accumulator reset
- acc_p  in  P_WIDTH  from accumulator P
- res_valid  out  1  result valid; held until res_ready
- res_data  out  P_WIDTH  signed job result
- res_id  out  $clog2(NUM_REQ)  requester index of result
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, RESULT.
- IDLE:
  - If any req_valid is high, grant lane g by round-robin from pointer ptr.
  - Pulse req_ready[g]; latch g, req_len[g] into remaining, req_sub[g].
  - Set ptr <= (g+1) mod NUM_REQ.
  - Go to CLEAR; if len==0, go to RESULT instead with res_data=0.
- CLEAR: acc_reset=1 for exactly one cycle, so P=0 at the next edge; go to RUN.
- RUN:
  - smp_ready[g]=1; sample handshake = smp_valid[g]&smp_ready[g].
  - On handshake: acc_a=smp_data[g] (combinational) and remaining decrements.
  - Otherwise acc_a=0. Adding or subtracting 0 leaves P unchanged, so gaps are harmless.
  - When the handshake with remaining==1 occurs, go to DRAIN.
- DRAIN: P now includes the last sample; capture res_data<=acc_p and res_id<=g; go to RESULT.
- RESULT:
  - res_valid=1; res_data and res_id stay stable until the res_ready handshake.
  - After the handshake, go to IDLE.
- acc_subtract = latched req_sub while busy, 0 in IDLE.
- acc_reset = reset | (state==CLEAR).
- acc_a = 0 outside a RUN handshake.
- Lanes that are not granted are ignored: their smp_valid never affects acc_a, and their smp_ready stays 0.
- Arithmetic is two's complement inside the accumulator. No overflow is possible under the P_WIDTH rule; no saturation.

## Timing
- Reset values:
  - state=IDLE, ptr=0, busy=0.
  - req_ready=0, smp_ready=0, res_valid=0, res_data=0, res_id=0.
  - acc_a=0, acc_subtract=0, acc_reset=1 (follows reset).
- Reset mid-job: return to IDLE next edge; the in-flight job is dropped with no result; the accumulator is cleared.
- Job of length N with samples every cycle:
  - accept = cycle 0
  - CLEAR = cycle 1
  - RUN = cycles 2..N+1
  - DRAIN = cycle N+2
  - res_valid from cycle N+3
- With res_ready high, the next job can be accepted at cycle N+4. Job period = N+4 cycles.
- len==0: res_valid at cycle 1 with data 0; the accumulator is untouched.
- req_valid deasserted before grant: the lane is simply not considered (no error).
- A new req_valid during busy waits; arbitration occurs only in IDLE.

## Structure
- Package accumulator_sched_pkg holds:
  - state enum (IDLE, CLEAR, RUN, DRAIN, RESULT)
  - default width constants (A_WIDTH=20, P_WIDTH=38, LEN_WIDTH=8)
- One sub-module: rr_arbiter.
  - Parameterised by NUM_REQ.
  - Inputs: req vector and ptr. Outputs: one-hot grant and encoded index. Combinational.
- accumulator_scheduler holds the FSM, the pointer, the job latches and the sample mux.

## Test plan
- Reset held 2 cycles:
  - busy=0, res_valid=0, req_ready=0, smp_ready=0, acc_reset=1.
  - Accumulator P=0.
- Lane 0, len=3, add, samples 5, -2, 20'hFFFFF:
  - req_ready[0] pulses in cycle 0; res_valid rises at cycle 6.
  - res_data=2, res_id=0.
- Lane 2, len=2, subtract, samples 100, 30:
  - res_data=-130, res_id=2; acc_subtract=1 throughout the job.
- All four lanes request simultaneously, len=1, sample=id+1:
  - Grants in order 0,1,2,3; results 1,2,3,4.
  - Then lanes 3 and 0 request together with ptr=0: lane 0 is granted first, then lane 3.
- Lane 1, len=4, samples all 1, smp_valid toggling every other cycle, res_ready low 5 cycles:
  - res_data=4; res_data and res_id are held stable while stalled.
- Edge cases:
  - len=0 on lane 1: res_valid in cycle 1 with res_data=0.
  - Reset asserted mid-RUN: no result is produced; the following lane-0 job (len=2, samples 7, 8) returns 15.

Source files
------------

// File: rtl/accumulator_sched_pkg.sv
// rtl/accumulator_sched_pkg.sv - shared state encoding and default widths for accumulator_scheduler
package accumulator_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    RESULT
  } state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_A_WIDTH   = 20;
  localparam int DEF_P_WIDTH   = 38;
  localparam int DEF_LEN_WIDTH = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] idx,
  output logic                found
);

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    // Walk the lanes cyclically from ptr; the first pending one wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && req[c[ID_WIDTH-1:0]]) begin
        found                   = 1'b1;
        grant[c[ID_WIDTH-1:0]]  = 1'b1;
        idx                     = c[ID_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/accumulator_scheduler.sv
// rtl/accumulator_scheduler.sv - round-robin job scheduler sharing one signed accumulator
module accumulator_scheduler
  import accumulator_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int P_WIDTH   = DEF_P_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_sub,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]     smp_data,
  input  logic [NUM_REQ-1:0]             smp_valid,
  output logic [NUM_REQ-1:0]             smp_ready,
  output logic signed [A_WIDTH-1:0]      acc_a,
  output logic                           acc_subtract,
  output logic                           acc_reset,
  input  logic signed [P_WIDTH-1:0]      acc_p,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [P_WIDTH-1:0]      res_data,
  output logic [ID_WIDTH-1:0]            res_id,
  output logic                           busy
);

  state_t                state;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   gid;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  sub;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   gidx;
  logic                  found;
  logic                  hs;

  logic signed [A_WIDTH-1:0] lane_data [NUM_REQ];
  logic [LEN_WIDTH-1:0]      lane_len  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_data[i] = smp_data[i*A_WIDTH +: A_WIDTH];
    assign lane_len[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .found (found)
  );

  assign hs           = (state == RUN) && smp_valid[gid];
  assign req_ready    = (state == IDLE && !reset) ? grant : '0;
  assign smp_ready    = (state == RUN && !reset) ? gnt_oh : '0;
  // Idle cycles feed zero so the accumulator holds P across sample gaps.
  assign acc_a        = (hs && !reset) ? lane_data[gid] : '0;
  assign acc_subtract = (state != IDLE) && sub;
  assign acc_reset    = reset || (state == CLEAR);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      gid       <= '0;
      gnt_oh    <= '0;
      remaining <= '0;
      sub       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gid       <= gidx;
            gnt_oh    <= grant;
            remaining <= lane_len[gidx];
            sub       <= req_sub[gidx];
            ptr       <= (gidx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gidx + ID_WIDTH'(1);
            if (lane_len[gidx] == '0) begin
              res_data  <= '0;
              res_id    <= gidx;
              res_valid <= 1'b1;
              state     <= RESULT;
            end else begin
              state <= CLEAR;
            end
          end
        end
        CLEAR: state <= RUN;
        RUN: begin
          if (hs) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          res_data  <= acc_p;
          res_id    <= gid;
          res_valid <= 1'b1;
          state     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_scheduler.sv
// tb/tb_accumulator_scheduler.sv - directed self-checking bench for accumulator_scheduler
module tb_accumulator_scheduler;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         req_valid, req_sub, req_ready, smp_valid, smp_ready;
  logic [31:0]        req_len;
  logic [79:0]        smp_data;
  logic signed [19:0] acc_a;
  logic               acc_subtract, acc_reset;
  logic signed [37:0] p_model;
  logic               res_valid, res_ready, busy;
  logic signed [37:0] res_data;
  logic [1:0]         res_id;

  int tests_run = 0;
  int tests_failed = 0;

  int                 lane_len [4];
  logic               lane_sub [4];
  logic signed [19:0] lane_smp [4][8];
  bit                 toggle;
  int                 stall;

  int                 gq[$];
  int                 gcq[$];
  logic signed [37:0] rdq[$];
  int                 riq[$];
  int                 first_rv;
  bit                 sub_bad, stable_bad, acc_bad, onehot_bad, timed_out;

  always #5 clk = ~clk;

  // Reference accumulator: one-cycle registered P <= P +/- A with synchronous clear.
  always_ff @(posedge clk) begin
    if (acc_reset) p_model <= '0;
    else if (acc_subtract) p_model <= p_model - {{18{acc_a[19]}}, acc_a};
    else p_model <= p_model + {{18{acc_a[19]}}, acc_a};
  end

  accumulator_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_sub(req_sub), .req_len(req_len), .req_ready(req_ready),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .acc_a(acc_a), .acc_subtract(acc_subtract), .acc_reset(acc_reset), .acc_p(p_model),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy)
  );

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; smp_valid = '0; res_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Drives the masked lanes until nres results are taken; called and returns at posedge+1.
  task automatic run_jobs(input logic [3:0] mask, input int nres);
    int cyc, seen, k;
    int sidx [4];
    bit phase, have_prev, cur_sub;
    logic [3:0] rr_word, hs_word;
    logic signed [37:0] prev_data;
    logic [1:0] prev_id;
    gq.delete(); gcq.delete(); rdq.delete(); riq.delete();
    first_rv = -1; sub_bad = 0; stable_bad = 0; acc_bad = 0; onehot_bad = 0; timed_out = 0;
    phase = 1; have_prev = 0; cur_sub = 0; seen = 0; cyc = 0;
    prev_data = '0; prev_id = '0;
    for (int i = 0; i < 4; i++) begin
      sidx[i] = 0;
      req_len[i*8 +: 8] = 8'(lane_len[i]);
      req_sub[i] = lane_sub[i];
      smp_data[i*20 +: 20] = lane_smp[i][0];
      smp_valid[i] = mask[i] && (lane_len[i] > 0);
    end
    req_valid = mask;
    res_ready = (stall == 0);
    while (rdq.size() < nres) begin
      if (cyc > 300) begin timed_out = 1; break; end
      @(negedge clk);
      if (busy && acc_subtract !== cur_sub) sub_bad = 1;
      if (!busy && acc_subtract !== 1'b0) sub_bad = 1;
      hs_word = smp_ready & smp_valid;
      if (hs_word == 4'b0 && acc_a !== 20'sd0) acc_bad = 1;
      rr_word = req_ready;
      if ($countones(req_ready) > 1) onehot_bad = 1;
      if (|req_ready) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (req_ready[i]) k = i;
        gq.push_back(k); gcq.push_back(cyc); cur_sub = lane_sub[k];
      end
      if (res_valid) begin
        if (first_rv < 0) first_rv = cyc;
        if (have_prev && (res_data !== prev_data || res_id !== prev_id)) stable_bad = 1;
        prev_data = res_data; prev_id = res_id; have_prev = 1;
        if (res_ready) begin
          rdq.push_back(res_data); riq.push_back(int'(res_id)); have_prev = 0; seen = 0;
        end else seen++;
      end
      @(posedge clk); #1;
      cyc++;
      phase = ~phase;
      req_valid = req_valid & ~rr_word;
      for (int i = 0; i < 4; i++) begin
        if (hs_word[i]) sidx[i]++;
        smp_data[i*20 +: 20] = lane_smp[i][sidx[i] & 7];
        smp_valid[i] = mask[i] && (sidx[i] < lane_len[i]) && (!toggle || phase);
      end
      res_ready = (stall == 0) || (seen >= stall);
    end
    req_valid = '0; smp_valid = '0; res_ready = 1'b0;
    if (timed_out) $display("FAIL run_jobs timeout: got %0d results required %0d", rdq.size(), nres);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0; req_sub = '0; req_len = '0; smp_data = '0; smp_valid = '0; res_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", busy); end
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid: got %b required 0", res_valid); end
    tests_run++; if (req_ready !== 4'b0) begin tests_failed++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
    tests_run++; if (smp_ready !== 4'b0) begin tests_failed++; $display("FAIL reset_smp_ready: got %b required 0", smp_ready); end
    tests_run++; if (acc_reset !== 1'b1) begin tests_failed++; $display("FAIL reset_acc_reset: got %b required 1", acc_reset); end
    tests_run++; if (p_model !== 38'sd0) begin tests_failed++; $display("FAIL reset_p: got %0d required 0", p_model); end
    tests_run++; if (acc_a !== 20'sd0 || acc_subtract !== 1'b0) begin tests_failed++; $display("FAIL reset_acc_in: got a=%0d sub=%b required 0/0", acc_a, acc_subtract); end
    tests_run++; if (res_data !== 38'sd0 || res_id !== 2'd0) begin tests_failed++; $display("FAIL reset_res: got %0d/%0d required 0/0", res_data, res_id); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_add();
    lane_len[0] = 3; lane_sub[0] = 0; stall = 0; toggle = 0;
    lane_smp[0][0] = 20'sd5; lane_smp[0][1] = -20'sd2; lane_smp[0][2] = 20'hFFFFF;
    run_jobs(4'b0001, 1);
    tests_run++; if (timed_out || gq.size() != 1 || gq[0] != 0 || gcq[0] != 0) begin tests_failed++; $display("FAIL add_grant: got n=%0d lane=%0d cyc=%0d required 1/0/0", gq.size(), gq[0], gcq[0]); end
    tests_run++; if (first_rv != 6) begin tests_failed++; $display("FAIL add_latency: got %0d required 6", first_rv); end
    tests_run++; if (rdq[0] !== 38'sd2 || riq[0] != 0) begin tests_failed++; $display("FAIL add_result: got %0d id %0d required 2 id 0", rdq[0], riq[0]); end
    tests_run++; if (sub_bad || acc_bad || onehot_bad) begin tests_failed++; $display("FAIL add_ctrl: got sub=%b acc=%b oh=%b required 000", sub_bad, acc_bad, onehot_bad); end
  endtask

  task automatic test_subtract();
    lane_len[2] = 2; lane_sub[2] = 1; stall = 0; toggle = 0;
    lane_smp[2][0] = 20'sd100; lane_smp[2][1] = 20'sd30;
    run_jobs(4'b0100, 1);
    tests_run++; if (timed_out || rdq[0] !== -38'sd130 || riq[0] != 2) begin tests_failed++; $display("FAIL sub_result: got %0d id %0d required -130 id 2", rdq[0], riq[0]); end
    tests_run++; if (sub_bad) begin tests_failed++; $display("FAIL sub_mode: got acc_subtract wrong required 1 while busy"); end
    tests_run++; if (first_rv != 5) begin tests_failed++; $display("FAIL sub_latency: got %0d required 5", first_rv); end
  endtask

  task automatic test_round_robin();
    do_reset();
    stall = 0; toggle = 0;
    for (int i = 0; i < 4; i++) begin
      lane_len[i] = 1; lane_sub[i] = 0; lane_smp[i][0] = 20'(i + 1);
    end
    run_jobs(4'b1111, 4);
    tests_run++; if (timed_out || gq.size() != 4 || gq[0] != 0 || gq[1] != 1 || gq[2] != 2 || gq[3] != 3) begin tests_failed++; $display("FAIL rr_order: got %p required 0 1 2 3", gq); end
    tests_run++; if (rdq.size() != 4 || rdq[0] !== 38'sd1 || rdq[1] !== 38'sd2 || rdq[2] !== 38'sd3 || rdq[3] !== 38'sd4) begin tests_failed++; $display("FAIL rr_data: got %p required 1 2 3 4", rdq); end
    tests_run++; if (riq.size() != 4 || riq[0] != 0 || riq[1] != 1 || riq[2] != 2 || riq[3] != 3) begin tests_failed++; $display("FAIL rr_id: got %p required 0 1 2 3", riq); end
    tests_run++; if (gcq.size() < 2 || gcq[1] - gcq[0] != 5) begin tests_failed++; $display("FAIL back_to_back_period: got %p required step 5", gcq); end
    tests_run++; if (acc_bad || onehot_bad) begin tests_failed++; $display("FAIL rr_ctrl: got acc=%b oh=%b required 00", acc_bad, onehot_bad); end
    lane_smp[0][0] = 20'sd11; lane_smp[3][0] = 20'sd44;
    run_jobs(4'b1001, 2);
    tests_run++; if (timed_out || gq.size() != 2 || gq[0] != 0 || gq[1] != 3) begin tests_failed++; $display("FAIL rr_wrap: got %p required 0 3", gq); end
    tests_run++; if (rdq.size() != 2 || rdq[0] !== 38'sd11 || rdq[1] !== 38'sd44) begin tests_failed++; $display("FAIL rr_wrap_data: got %p required 11 44", rdq); end
  endtask

  task automatic test_stall();
    lane_len[1] = 4; lane_sub[1] = 0; stall = 5; toggle = 1;
    for (int j = 0; j < 4; j++) lane_smp[1][j] = 20'sd1;
    run_jobs(4'b0010, 1);
    tests_run++; if (timed_out || rdq[0] !== 38'sd4 || riq[0] != 1) begin tests_failed++; $display("FAIL stall_result: got %0d id %0d required 4 id 1", rdq[0], riq[0]); end
    tests_run++; if (stable_bad) begin tests_failed++; $display("FAIL stall_hold: got changing res_data/res_id required stable"); end
    tests_run++; if (acc_bad) begin tests_failed++; $display("FAIL stall_gap_acc_a: got nonzero acc_a in gap required 0"); end
  endtask

  task automatic test_zero_len();
    logic signed [37:0] p_before;
    p_before = p_model;
    lane_len[1] = 0; lane_sub[1] = 0; stall = 0; toggle = 0;
    run_jobs(4'b0010, 1);
    tests_run++; if (timed_out || first_rv != 1) begin tests_failed++; $display("FAIL zero_latency: got %0d required 1", first_rv); end
    tests_run++; if (rdq[0] !== 38'sd0 || riq[0] != 1) begin tests_failed++; $display("FAIL zero_result: got %0d id %0d required 0 id 1", rdq[0], riq[0]); end
    tests_run++; if (p_model !== p_before) begin tests_failed++; $display("FAIL zero_acc_untouched: got %0d required %0d", p_model, p_before); end
  endtask

  task automatic test_reset_mid_run();
    bit seen_run, spurious;
    seen_run = 0; spurious = 0;
    req_len[16 +: 8] = 8'd5; req_sub[2] = 1'b0;
    smp_data[40 +: 20] = 20'sd50; smp_valid = 4'b0100; req_valid = 4'b0100;
    for (int i = 0; i < 20 && !seen_run; i++) begin
      @(negedge clk);
      if (smp_ready[2]) seen_run = 1;
      if (req_ready[2]) begin @(posedge clk); #1; req_valid = '0; end
    end
    tests_run++; if (!seen_run) begin tests_failed++; $display("FAIL midrun_reach_run: got no smp_ready required RUN"); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; req_valid = '0; smp_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || smp_ready !== 4'b0) begin tests_failed++; $display("FAIL midrun_idle: got busy=%b smp_ready=%b required 0/0", busy, smp_ready); end
    tests_run++; if (p_model !== 38'sd0) begin tests_failed++; $display("FAIL midrun_acc_clear: got %0d required 0", p_model); end
    for (int i = 0; i < 8; i++) begin
      if (res_valid) spurious = 1;
      @(negedge clk);
    end
    tests_run++; if (spurious) begin tests_failed++; $display("FAIL midrun_no_result: got res_valid required none"); end
    @(posedge clk); #1;
    lane_len[0] = 2; lane_sub[0] = 0; stall = 0; toggle = 0;
    lane_smp[0][0] = 20'sd7; lane_smp[0][1] = 20'sd8;
    run_jobs(4'b0001, 1);
    tests_run++; if (timed_out || rdq[0] !== 38'sd15 || riq[0] != 0) begin tests_failed++; $display("FAIL midrun_next_job: got %0d id %0d required 15 id 0", rdq[0], riq[0]); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      lane_len[i] = 0; lane_sub[i] = 0;
      for (int j = 0; j < 8; j++) lane_smp[i][j] = '0;
    end
    toggle = 0; stall = 0;
    test_reset();
    test_add();
    test_subtract();
    test_round_robin();
    test_stall();
    test_zero_len();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
